// File: rtl/rv_iommu_ddtc_ctrl.sv
// rv_iommu_ddtc_ctrl: arbitrates DDTC access between lookup requesters,
// the DDT walker (fills) and the command queue (flushes). Only one DDTC
// command is ever driven at a time. Each op runs a four-phase handshake:
// command up, wait for done, command down, wait for done low, respond.
// A watchdog aborts any phase that stalls for TIMEOUT cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | pick flush > fill > round-robin lookup, register its operands
// LKUP    | drive ddtc_lookup_o until lkup/fill done, latch hit
// FILL    | drive ddtc_fill_o until lkup/fill done
// FLUSH   | drive ddtc_flush_o until flush done
// RELEASE | commands low, wait for done low, then pulse the response

module rv_iommu_ddtc_ctrl #(
  parameter int NUM_LKUP = 4,
  parameter int DID_W    = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LKUP-1:0]         lkup_req_valid_i,
  input  logic [NUM_LKUP*DID_W-1:0]   lkup_req_did_i,
  output logic [NUM_LKUP-1:0]         lkup_req_ready_o,
  output logic                        lkup_rsp_valid_o,
  output logic [((NUM_LKUP > 1) ? $clog2(NUM_LKUP) : 1)-1:0] lkup_rsp_id_o,
  output logic                        lkup_rsp_hit_o,
  input  logic                        fill_req_valid_i,
  input  logic [DID_W-1:0]            fill_req_did_i,
  output logic                        fill_done_o,
  input  logic                        flush_req_valid_i,
  input  logic [DID_W-1:0]            flush_did_i,
  input  logic                        flush_did_valid_i,
  output logic                        flush_done_o,
  output logic                        err_timeout_o,
  output logic                        ddtc_lookup_o,
  output logic                        ddtc_fill_o,
  output logic                        ddtc_flush_o,
  output logic [DID_W-1:0]            ddtc_device_id_o,
  output logic [DID_W-1:0]            ddtc_flush_did_o,
  output logic                        ddtc_flush_did_valid_o,
  input  logic                        ddtc_lkup_fill_done_i,
  input  logic                        ddtc_hit_i,
  input  logic                        ddtc_flush_done_i
);

  localparam int IDW = (NUM_LKUP > 1) ? $clog2(NUM_LKUP) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LKUP, S_FILL, S_FLUSH, S_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    OP_LKUP, OP_FILL, OP_FLUSH
  } op_t;

  state_t                state_q;
  op_t                   op_q;
  logic [WDW-1:0]        wd_q;
  logic [IDW-1:0]        rr_ptr_q;
  logic                  hit_q;
  logic [NUM_LKUP-1:0]   ready_q;
  logic                  rsp_valid_q;
  logic [IDW-1:0]        rsp_id_q;
  logic                  rsp_hit_q;
  logic                  fill_done_q;
  logic                  flush_done_q;
  logic                  err_q;
  logic                  ddtc_lookup_q;
  logic                  ddtc_fill_q;
  logic                  ddtc_flush_q;
  logic [DID_W-1:0]      dev_id_q;
  logic [DID_W-1:0]      flush_did_q;
  logic                  flush_did_valid_q;

  logic                  grant_vld_d;
  logic [IDW-1:0]        grant_idx_d;
  logic [NUM_LKUP-1:0]   grant_oh_d;
  logic [DID_W-1:0]      grant_did_d;
  logic [IDW-1:0]        rr_ptr_d;

  logic                  cmd_done;
  logic                  rel_done_hi;
  logic                  wd_expired;

  // Round-robin pick: first pass from the pointer upward, second pass wraps to 0
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    grant_oh_d  = '0;
    grant_did_d = '0;
    for (int j = 0; j < NUM_LKUP; j++) begin
      if (!grant_vld_d && lkup_req_valid_i[j] && (j >= int'(rr_ptr_q))) begin
        grant_vld_d   = 1'b1;
        grant_idx_d   = IDW'(j);
        grant_oh_d[j] = 1'b1;
        grant_did_d   = lkup_req_did_i[j*DID_W +: DID_W];
      end
    end
    for (int j = 0; j < NUM_LKUP; j++) begin
      if (!grant_vld_d && lkup_req_valid_i[j]) begin
        grant_vld_d   = 1'b1;
        grant_idx_d   = IDW'(j);
        grant_oh_d[j] = 1'b1;
        grant_did_d   = lkup_req_did_i[j*DID_W +: DID_W];
      end
    end
    rr_ptr_d = (grant_idx_d == IDW'(NUM_LKUP - 1)) ? '0 : grant_idx_d + IDW'(1);
  end

  // Done is only honoured while our own command is up, so a stale done left
  // high by an aborted op cannot complete the next one.
  assign cmd_done    = ddtc_lkup_fill_done_i && (ddtc_lookup_q || ddtc_fill_q);
  assign rel_done_hi = (op_q == OP_FLUSH) ? ddtc_flush_done_i : ddtc_lkup_fill_done_i;
  assign wd_expired  = (wd_q >= WD_MAX);

  // Sequencer: arbitration, handshake, watchdog and registered response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      op_q              <= OP_LKUP;
      wd_q              <= '0;
      rr_ptr_q          <= '0;
      hit_q             <= 1'b0;
      ready_q           <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= '0;
      rsp_hit_q         <= 1'b0;
      fill_done_q       <= 1'b0;
      flush_done_q      <= 1'b0;
      err_q             <= 1'b0;
      ddtc_lookup_q     <= 1'b0;
      ddtc_fill_q       <= 1'b0;
      ddtc_flush_q      <= 1'b0;
      dev_id_q          <= '0;
      flush_did_q       <= '0;
      flush_did_valid_q <= 1'b0;
    end else begin
      ready_q      <= '0;
      rsp_valid_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (flush_req_valid_i) begin
            flush_did_q       <= flush_did_i;
            flush_did_valid_q <= flush_did_valid_i;
            op_q              <= OP_FLUSH;
            state_q           <= S_FLUSH;
          end else if (fill_req_valid_i) begin
            dev_id_q <= fill_req_did_i;
            op_q     <= OP_FILL;
            state_q  <= S_FILL;
          end else if (grant_vld_d) begin
            ready_q  <= grant_oh_d;
            dev_id_q <= grant_did_d;
            rsp_id_q <= grant_idx_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= OP_LKUP;
            state_q  <= S_LKUP;
          end
        end
        S_LKUP, S_FILL: begin
          if (cmd_done) begin
            ddtc_lookup_q <= 1'b0;
            ddtc_fill_q   <= 1'b0;
            hit_q         <= (op_q == OP_LKUP) && ddtc_hit_i;
            wd_q          <= '0;
            state_q       <= S_RELEASE;
          end else if (wd_expired) begin
            err_q         <= 1'b1;
            ddtc_lookup_q <= 1'b0;
            ddtc_fill_q   <= 1'b0;
            hit_q         <= 1'b0;
            wd_q          <= '0;
            state_q       <= S_RELEASE;
          end else begin
            wd_q          <= wd_q + WDW'(1);
            ddtc_lookup_q <= (op_q == OP_LKUP);
            ddtc_fill_q   <= (op_q == OP_FILL);
          end
        end
        S_FLUSH: begin
          if (ddtc_flush_done_i && ddtc_flush_q) begin
            ddtc_flush_q <= 1'b0;
            wd_q         <= '0;
            state_q      <= S_RELEASE;
          end else if (wd_expired) begin
            err_q        <= 1'b1;
            ddtc_flush_q <= 1'b0;
            wd_q         <= '0;
            state_q      <= S_RELEASE;
          end else begin
            wd_q         <= wd_q + WDW'(1);
            ddtc_flush_q <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (!rel_done_hi || wd_expired) begin
            // a release that times out still answers, but never as a hit
            err_q   <= rel_done_hi;
            wd_q    <= '0;
            state_q <= S_IDLE;
            case (op_q)
              OP_LKUP: begin
                rsp_valid_q <= 1'b1;
                rsp_hit_q   <= hit_q && !rel_done_hi;
              end
              OP_FILL:  fill_done_q  <= 1'b1;
              default:  flush_done_q <= 1'b1;
            endcase
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lkup_req_ready_o       = ready_q;
  assign lkup_rsp_valid_o       = rsp_valid_q;
  assign lkup_rsp_id_o          = rsp_id_q;
  assign lkup_rsp_hit_o         = rsp_hit_q;
  assign fill_done_o            = fill_done_q;
  assign flush_done_o           = flush_done_q;
  assign err_timeout_o          = err_q;
  assign ddtc_lookup_o          = ddtc_lookup_q;
  assign ddtc_fill_o            = ddtc_fill_q;
  assign ddtc_flush_o           = ddtc_flush_q;
  assign ddtc_device_id_o       = dev_id_q;
  assign ddtc_flush_did_o       = flush_did_q;
  assign ddtc_flush_did_valid_o = flush_did_valid_q;

endmodule

// File: tb/tb_rv_iommu_ddtc_ctrl.sv
// Directed bench for rv_iommu_ddtc_ctrl with a small registered DDTC stub.
module tb_rv_iommu_ddtc_ctrl;

  localparam int NUM_LKUP = 4;
  localparam int DID_W    = 24;
  localparam int TIMEOUT  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_LKUP-1:0]       lkup_req_valid;
  logic [NUM_LKUP*DID_W-1:0] lkup_req_did;
  logic [NUM_LKUP-1:0]       lkup_req_ready;
  logic                      lkup_rsp_valid;
  logic [1:0]                lkup_rsp_id;
  logic                      lkup_rsp_hit;
  logic                      fill_req_valid;
  logic [DID_W-1:0]          fill_req_did;
  logic                      fill_done;
  logic                      flush_req_valid;
  logic [DID_W-1:0]          flush_did;
  logic                      flush_did_valid;
  logic                      flush_done;
  logic                      err_timeout;
  logic                      ddtc_lookup, ddtc_fill, ddtc_flush;
  logic [DID_W-1:0]          ddtc_device_id;
  logic [DID_W-1:0]          ddtc_flush_did;
  logic                      ddtc_flush_did_valid;
  logic                      ddtc_lf_done;
  logic                      ddtc_hit;
  logic                      ddtc_fl_done;

  always #5 clk = ~clk;

  rv_iommu_ddtc_ctrl #(.NUM_LKUP(NUM_LKUP), .DID_W(DID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .lkup_req_valid_i(lkup_req_valid), .lkup_req_did_i(lkup_req_did),
    .lkup_req_ready_o(lkup_req_ready), .lkup_rsp_valid_o(lkup_rsp_valid),
    .lkup_rsp_id_o(lkup_rsp_id), .lkup_rsp_hit_o(lkup_rsp_hit),
    .fill_req_valid_i(fill_req_valid), .fill_req_did_i(fill_req_did),
    .fill_done_o(fill_done),
    .flush_req_valid_i(flush_req_valid), .flush_did_i(flush_did),
    .flush_did_valid_i(flush_did_valid), .flush_done_o(flush_done),
    .err_timeout_o(err_timeout),
    .ddtc_lookup_o(ddtc_lookup), .ddtc_fill_o(ddtc_fill), .ddtc_flush_o(ddtc_flush),
    .ddtc_device_id_o(ddtc_device_id), .ddtc_flush_did_o(ddtc_flush_did),
    .ddtc_flush_did_valid_o(ddtc_flush_did_valid),
    .ddtc_lkup_fill_done_i(ddtc_lf_done), .ddtc_hit_i(ddtc_hit),
    .ddtc_flush_done_i(ddtc_fl_done)
  );

  // DDTC stub: done follows the command one clock later; 4-entry table
  logic              stub_en;
  logic [DID_W-1:0]  tbl [4];
  logic [3:0]        tbl_v;
  int                wr_ptr;
  logic              tbl_hit;

  always_comb begin
    tbl_hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (tbl_v[i] && (tbl[i] == ddtc_device_id)) tbl_hit = 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      ddtc_lf_done <= 1'b0;
      ddtc_fl_done <= 1'b0;
      ddtc_hit     <= 1'b0;
      tbl_v        <= '0;
      wr_ptr       <= 0;
    end else begin
      ddtc_lf_done <= stub_en & (ddtc_lookup | ddtc_fill);
      ddtc_fl_done <= stub_en & ddtc_flush;
      if (ddtc_lookup) ddtc_hit <= tbl_hit;
      if (stub_en && ddtc_fill && !ddtc_lf_done) begin
        tbl[wr_ptr]   <= ddtc_device_id;
        tbl_v[wr_ptr] <= 1'b1;
        wr_ptr        <= (wr_ptr + 1) % 4;
      end
      if (stub_en && ddtc_flush && !ddtc_fl_done) begin
        for (int i = 0; i < 4; i++)
          if (!ddtc_flush_did_valid || tbl[i] == ddtc_flush_did) tbl_v[i] <= 1'b0;
      end
    end
  end

  // Sticky protocol monitors, checked at the end
  logic excl_bad = 1'b0;
  logic oh_bad   = 1'b0;
  always @(negedge clk) begin
    if ($countones({ddtc_lookup, ddtc_fill, ddtc_flush}) > 1) excl_bad <= 1'b1;
    if ($countones(lkup_req_ready) > 1) oh_bad <= 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 rsp_valid, 1 fill_done, 2 flush_done, 3 err, 4 any ready, 5 ddtc_lookup
  task automatic wait_sig(input int which, input int lim, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= lim && n < 0; i++) begin
      step();
      case (which)
        0:       hit = lkup_rsp_valid;
        1:       hit = fill_done;
        2:       hit = flush_done;
        3:       hit = err_timeout;
        4:       hit = |lkup_req_ready;
        default: hit = ddtc_lookup;
      endcase
      if (hit) n = i;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {lkup_req_ready, lkup_rsp_valid, lkup_rsp_id, lkup_rsp_hit, fill_done,
            flush_done, err_timeout, ddtc_lookup, ddtc_fill, ddtc_flush,
            ddtc_device_id, ddtc_flush_did, ddtc_flush_did_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int n;
  int ev [3];
  int nev;
  int gidx [5];
  int gcyc [5];
  int g;
  int cnt;
  logic saw_fdv;

  initial begin
    rst = 1'b1;
    stub_en = 1'b1;
    lkup_req_valid = '0;
    lkup_req_did = '0;
    fill_req_valid = 1'b0;
    fill_req_did = '0;
    flush_req_valid = 1'b0;
    flush_did = '0;
    flush_did_valid = 1'b0;
    step(); step(); step();
    check("reset_outputs", all_outs(), 64'h0);
    rst = 1'b0;
    step();

    // 1: single lookup miss, exact latency
    lkup_req_did[0*DID_W +: DID_W] = 24'h000123;
    lkup_req_valid[0] = 1'b1;
    step();
    check("t1_ready", 64'(lkup_req_ready), 64'h1);
    check("t1_no_cmd_at_accept", 64'(ddtc_lookup), 64'h0);
    lkup_req_valid[0] = 1'b0;
    step();
    check("t1_lookup_cmd", 64'(ddtc_lookup), 64'h1);
    check("t1_device_id", 64'(ddtc_device_id), 64'h000123);
    wait_sig(0, 20, n);
    check("t1_rsp_latency", 64'(n + 1), 64'd5);
    check("t1_rsp_id", 64'(lkup_rsp_id), 64'd0);
    check("t1_rsp_hit", 64'(lkup_rsp_hit), 64'd0);

    // 2: fill then hitting lookup from requester 2
    fill_req_did = 24'h000123;
    fill_req_valid = 1'b1;
    wait_sig(1, 30, n);
    check("t2_fill_latency", 64'(n), 64'd6);
    fill_req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fill_done) cnt++;
    end
    check("t2_fill_done_once", 64'(cnt), 64'd0);
    lkup_req_did[2*DID_W +: DID_W] = 24'h000123;
    lkup_req_valid[2] = 1'b1;
    wait_sig(4, 10, n);
    check("t2_ready", 64'(lkup_req_ready), 64'h4);
    lkup_req_valid[2] = 1'b0;
    wait_sig(0, 20, n);
    check("t2_rsp_latency", 64'(n), 64'd5);
    check("t2_rsp_id", 64'(lkup_rsp_id), 64'd2);
    check("t2_rsp_hit", 64'(lkup_rsp_hit), 64'd1);
    check("t2_ddtc_did_held", 64'(ddtc_device_id), 64'h000123);

    // 4: flush-all, fill and req1 in the same cycle
    flush_did = 24'h000123;
    flush_did_valid = 1'b0;
    flush_req_valid = 1'b1;
    fill_req_did = 24'h000777;
    fill_req_valid = 1'b1;
    lkup_req_did[1*DID_W +: DID_W] = 24'h000123;
    lkup_req_valid[1] = 1'b1;
    nev = 0;
    saw_fdv = 1'b1;
    for (int i = 0; i < 80 && nev < 3; i++) begin
      step();
      if (ddtc_flush) saw_fdv = ddtc_flush_did_valid;
      if (flush_done) begin ev[nev] = 1; nev++; flush_req_valid = 1'b0; end
      if (fill_done)  begin ev[nev] = 2; nev++; fill_req_valid = 1'b0; end
      if (lkup_req_ready[1]) lkup_req_valid[1] = 1'b0;
      if (lkup_rsp_valid) begin ev[nev] = 3; nev++; end
    end
    check("t4_events", 64'(nev), 64'd3);
    check("t4_first_flush", 64'(ev[0]), 64'd1);
    check("t4_second_fill", 64'(ev[1]), 64'd2);
    check("t4_third_lookup", 64'(ev[2]), 64'd3);
    check("t4_flush_all_qual", 64'(saw_fdv), 64'd0);
    check("t4_rsp_id", 64'(lkup_rsp_id), 64'd1);
    check("t4_rsp_hit", 64'(lkup_rsp_hit), 64'd0);

    // 5: DDTC never answers, watchdog aborts the lookup
    stub_en = 1'b0;
    lkup_req_did[2*DID_W +: DID_W] = 24'h000555;
    lkup_req_valid[2] = 1'b1;
    wait_sig(4, 10, n);
    check("t5_ready", 64'(lkup_req_ready), 64'h4);
    lkup_req_valid[2] = 1'b0;
    wait_sig(5, 5, n);
    check("t5_cmd_up", 64'(n), 64'd1);
    wait_sig(3, 40, n);
    check("t5_err_after_cmd", 64'(n), 64'd16);
    check("t5_cmd_dropped", 64'(ddtc_lookup), 64'd0);
    wait_sig(0, 5, n);
    check("t5_rsp_after_err", 64'(n), 64'd1);
    check("t5_rsp_id", 64'(lkup_rsp_id), 64'd2);
    check("t5_rsp_hit", 64'(lkup_rsp_hit), 64'd0);
    stub_en = 1'b1;
    step();

    // 6: reset while a lookup from requester 1 is in flight
    lkup_req_did[1*DID_W +: DID_W] = 24'h000042;
    lkup_req_valid[1] = 1'b1;
    wait_sig(4, 10, n);
    check("t6_ready", 64'(lkup_req_ready), 64'h2);
    lkup_req_valid[1] = 1'b0;
    wait_sig(5, 5, n);
    check("t6_cmd_up", 64'(n), 64'd1);
    rst = 1'b1;
    step();
    check("t6_reset_outputs", all_outs(), 64'h0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (lkup_rsp_valid) cnt++;
    end
    check("t6_no_rsp", 64'(cnt), 64'd0);

    // 3: all requesters valid continuously, pointer restarts at 0
    for (int k = 0; k < NUM_LKUP; k++) lkup_req_did[k*DID_W +: DID_W] = 24'(32'h100 + k);
    lkup_req_valid = '1;
    g = 0;
    for (int c = 1; c <= 100 && g < 5; c++) begin
      step();
      if (lkup_req_ready != '0) begin
        gidx[g] = 0;
        for (int k = 0; k < NUM_LKUP; k++) if (lkup_req_ready[k]) gidx[g] = k;
        gcyc[g] = c;
        g++;
      end
    end
    lkup_req_valid = '0;
    check("t3_grant_count", 64'(g), 64'd5);
    for (int k = 0; k < 5; k++) check("t3_grant_order", 64'(gidx[k]), 64'(k % 4));
    check("t3_peak_rate", 64'(gcyc[1] - gcyc[0]), 64'd6);
    wait_sig(0, 20, n);
    check("t3_last_rsp_id", 64'(lkup_rsp_id), 64'd0);

    check("cmd_mutual_exclusion", 64'(excl_bad), 64'd0);
    check("ready_onehot", 64'(oh_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
